// File: rtl/core_pkg.sv
// Constants and types shared by the fetch stage, instruction queue and decoder.
package core_pkg;
  localparam int ADDR_W          = 16;
  localparam int INSTR_W         = 44;
  localparam int QUEUE_DEPTH     = 8;
  localparam int WORD_W          = 16;
  localparam int WORDS_PER_INSTR = 3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_assembler.sv
// Packs sequential 16-bit memory words into one instruction. word_idx parks at
// WORDS_PER_INSTR while a finished instruction waits in asm for the hold register.
module fetch_assembler import core_pkg::*; #(
  parameter int INSTR_W = core_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               capture,
  input  logic               take,
  input  logic [WORD_W-1:0]  data,
  output logic [1:0]         word_idx,
  output logic               last,
  output logic [INSTR_W-1:0] asm_nxt
);
  localparam int FULL_W = WORD_W * WORDS_PER_INSTR;

  logic [INSTR_W-1:0] asm_q;
  logic [FULL_W-1:0]  merged;

  // Bits of the last word beyond INSTR_W fall off in the truncation below.
  always_comb begin
    merged = FULL_W'(asm_q);
    for (int w = 0; w < WORDS_PER_INSTR; w++)
      if (capture && word_idx == 2'(w)) merged[WORD_W*w +: WORD_W] = data;
  end

  assign asm_nxt = merged[INSTR_W-1:0];
  assign last    = word_idx == 2'(WORDS_PER_INSTR - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_idx <= '0;
      asm_q    <= '0;
    end else if (clr) begin
      word_idx <= '0;
      asm_q    <= '0;
    end else begin
      if (capture) asm_q <= asm_nxt;
      if (capture && !last)  word_idx <= word_idx + 2'd1;
      else if (take)         word_idx <= '0;
      else if (capture)      word_idx <= 2'(WORDS_PER_INSTR);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: sequential word reads, 3-word assembly, hold register feeding the queue.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cycles / instr_count outputs.
module instruction_fetch import core_pkg::*; #(
  parameter int                ADDR_W      = core_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_W     = core_pkg::INSTR_W,
  parameter int                QUEUE_DEPTH = core_pkg::QUEUE_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_data,
  output logic [INSTR_W-1:0] q_din,
  output logic               q_we,
  input  logic [7:0]         q_used,
  output logic [ADDR_W-1:0]  pc,
  output logic               flushed
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        instr_count
`endif
);
  fetch_state_t       state, state_nxt;
  logic [INSTR_W-1:0] hold, asm_nxt;
  logic               hold_valid, q_room, capture, take, last, hold_free;
  logic [1:0]         word_idx;

  assign q_room    = q_used < 8'(QUEUE_DEPTH);
  assign q_we      = hold_valid && q_room && !redirect;
  assign q_din     = hold;
  assign mem_req   = state == REQ;
  assign mem_addr  = pc;
  assign capture   = mem_req && mem_ack && !redirect;
  assign hold_free = !hold_valid || q_we;

  fetch_assembler #(.INSTR_W(INSTR_W)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (redirect),
    .capture  (capture),
    .take     (take),
    .data     (mem_data),
    .word_idx (word_idx),
    .last     (last),
    .asm_nxt  (asm_nxt)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = REQ;
      REQ: begin
        if (capture && last) begin
          if (hold_free) begin
            take      = 1'b1;
            state_nxt = en ? REQ : IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (!capture && !en && word_idx == 2'd0) begin
          // only leave between groups; a started group always completes
          state_nxt = IDLE;
        end
      end
      WAIT: if (q_we) begin
        take      = 1'b1;
        state_nxt = en ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      take      = 1'b0;
      state_nxt = en ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      hold       <= '0;
      hold_valid <= 1'b0;
      flushed    <= 1'b0;
    end else begin
      state   <= state_nxt;
      flushed <= redirect;
      if (redirect) begin
        pc         <= redirect_pc;
        hold_valid <= 1'b0;
      end else begin
        if (capture) pc <= pc + ADDR_W'(1);
        if (take) begin
          hold       <= asm_nxt;
          hold_valid <= 1'b1;
        end else if (q_we) begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      instr_count  <= '0;
    end else begin
      if (hold_valid && !q_room && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (q_we && instr_count != '1)                   instr_count  <= instr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + random bench for instruction_fetch; memory is a pure function of address
// and every queue write is checked against the next expected 3-word group.
module tb_instruction_fetch;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, redirect = 1'b0, mem_ack = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [7:0]  q_used = '0;
  logic [15:0] mem_data, mem_addr, pc;
  logic        mem_req, q_we, flushed;
  logic [43:0] q_din;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, instr_count;
`endif

  int          tests = 0, fails = 0;
  logic [15:0] mpc, exp_start, wr_pc;
  int          acks, wr;
  logic        prev_red;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .q_din(q_din), .q_we(q_we), .q_used(q_used), .pc(pc), .flushed(flushed)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memw(input logic [15:0] a);
    logic [15:0] h;
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'hF333;
      default: begin
        h = a * 16'h9E37;
        return h ^ {a[7:0], a[15:8]};
      end
    endcase
  endfunction

  function automatic logic [43:0] instr(input logic [15:0] s);
    logic [15:0] w0, w1, w2;
    w0 = memw(s);
    w1 = memw(s + 16'd1);
    w2 = memw(s + 16'd2);
    return {w2[11:0], w1, w0};
  endfunction

  assign mem_data = memw(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mpc = '0; exp_start = '0; acks = 0; wr = 0; prev_red = 1'b0;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, return at +1.
  task automatic cyc();
    logic acc, wrote, red;
    @(negedge clk);
    chk("pc", pc, mpc);
    chk("flushed", flushed, prev_red);
    if (mem_req)          chk("mem_addr", mem_addr, mpc);
    if (redirect)         chk("qwe_redirect", q_we, 0);
    if (q_used >= 8'd8)   chk("qwe_full", q_we, 0);
    if (q_we) begin
      chk("q_din", q_din, instr(exp_start));
      wr_pc = pc;
    end
    wrote = q_we; red = redirect; acc = mem_req && mem_ack && !redirect;
    @(posedge clk);
    prev_red = red;
    if (red) begin
      mpc = redirect_pc; exp_start = redirect_pc; acks = 0; wr = 0;
    end else begin
      if (acc)   begin mpc++; acks++; end
      if (wrote) begin exp_start += 16'd3; wr++; end
    end
    #1;
  endtask

  task automatic run_writes(input int n, input int budget);
    int k = 0;
    while (wr < n && k < budget) begin cyc(); k++; end
    chk("write_timeout", (wr >= n) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; redirect = 1'b0; mem_ack = 1'b0; q_used = '0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_q_we", q_we, 0);
    chk("rst_flushed", flushed, 0);
    chk("rst_pc", pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall", stall_cycles, 0);
    chk("rst_icount", instr_count, 0);
`endif
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    // basic assembly and first-write latency
    do_reset();
    en = 1'b1; mem_ack = 1'b1; q_used = 8'd0;
    repeat (4) cyc();
    chk("first_qwe", q_we, 1);
    chk("first_qdin", q_din, 44'h333_2222_1111);
    chk("first_pc", pc, 16'd3);
    repeat (4) cyc();

    // queue full: two instructions parked, then drained in order
    do_reset();
    en = 1'b1; mem_ack = 1'b1; q_used = 8'd8;
    repeat (12) cyc();
    chk("wait_mem_req", mem_req, 0);
    chk("wait_q_we", q_we, 0);
    en = 1'b0; q_used = 8'd7;
    repeat (6) cyc();
    chk("drain_writes", wr, 2);
    chk("drain_mem_req", mem_req, 0);

    // redirect on the second ack of a group
    do_reset();
    en = 1'b1; mem_ack = 1'b1;
    cyc(); cyc();
    redirect = 1'b1; redirect_pc = 16'h0100;
    cyc();
    redirect = 1'b0;
    chk("redir_addr", mem_addr, 16'h0100);
    chk("redir_req", mem_req, 1);
    run_writes(1, 20);

    // wrap at top of address space
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    redirect = 1'b0;
    run_writes(1, 20);
    chk("wrap_pc", wr_pc, 16'h0002);

    // async reset mid-assembly with hold occupied
    do_reset();
    en = 1'b1; mem_ack = 1'b1; q_used = 8'd8;
    repeat (5) cyc();
    q_used = 8'd0;
    #1;
    chk("pre_rst_qwe", q_we, 1);
    rst = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_q_we", q_we, 0);
    chk("arst_flushed", flushed, 0);
    chk("arst_pc", pc, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    run_writes(2, 30);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    en = 1'b1; mem_ack = 1'b1; q_used = 8'd8;
    repeat (5) cyc();
    en = 1'b0;
    repeat (4) cyc();
    q_used = 8'd0;
    repeat (3) cyc();
    chk("stall_cycles", stall_cycles, 5);
    chk("instr_count", instr_count, 2);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom % 8) != 0;
      mem_ack     = $urandom % 2;
      redirect    = ($urandom % 50) == 0;
      redirect_pc = ($urandom % 4 == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      q_used      = ($urandom % 3 == 0) ? 8'd8 : 8'($urandom_range(0, 8));
      cyc();
    end
    en = 1'b0; redirect = 1'b0; mem_ack = 1'b1; q_used = 8'd0;
    repeat (20) cyc();
    chk("rand_groups_whole", acks % 3, 0);
    chk("rand_no_loss", wr, acks / 3);
    chk("rand_idle", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
